bus_dma_engine: RTL and testbench
=================================

# bus_dma_engine

Word-copy DMA engine that acts as a second initiator on the SoC's ready-handshake system bus, in the same position as the pipelined core. It sits on a host port of a bus hub and moves `len_words` 32-bit words from a source region to a destination region: one read, then one write, per word. Control is a simple start/done sideband driven by a control register block or a testbench. The engine recovers from unmapped addresses through a per-request timeout.

## Interface
- `TIMEOUT_CYCLES`, default 255: requesting cycles without `bus_ready` before the transfer aborts with error. Must be ≥ 2.
- `LEN_W`, default 16: width of the word-count fields.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  sampled only in IDLE; launches a transfer.
- `src_addr`  in  32  source byte address. Bits [1:0] are ignored (treated as 0).
- `dst_addr`  in  32  destination byte address. Bits [1:0] are ignored.
- `len_words`  in  LEN_W  number of words to copy. 0 is legal.
- `abort`  in  1  request early stop, honoured at the next word boundary.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  valid with `done`; held until next accepted `start`.
- `err_addr`  out  32  address of the timed-out request; held like `error`.
- `words_done`  out  LEN_W  count of completed writes; cleared on `start`.
- `bus_addr`  out  32  request address, word-aligned.
- `bus_wdata`  out  32  write data.
- `bus_wmask`  out  4  always 4'b1111 while `bus_wen` is high, else 0.
- `bus_wen`  out  1  write request.
- `bus_ren`  out  1  read request.
- `bus_rdata`  in  32  read data, valid in the `bus_ready` cycle.
- `bus_ready`  in  1  device completion pulse.

## Operation
- States: IDLE, READ, RGAP, WRITE, WGAP, FINISH.
- IDLE, `start`=1:
  - latch `src_addr`, `dst_addr` and `len_words`; clear `words_done`, `error` and `err_addr`.
  - `len_words`=0 → FINISH; otherwise → READ.
- READ: drive `bus_ren`=1 with `bus_addr` = current source address.
  - On `bus_ready`: capture `bus_rdata`, source address += 4 → RGAP.
- RGAP: all requests low for one cycle → WRITE.
- WRITE: drive `bus_wen`=1, `bus_addr` = current destination address, `bus_wdata` = captured word.
  - On `bus_ready`: `words_done`++, destination address += 4.
  - If `words_done` then equals length, or `abort` was seen → FINISH; else → WGAP.
- WGAP: one idle cycle.
  - `abort` seen → FINISH; else → READ.
- FINISH: `done`=1 for one cycle, `busy`=0 → IDLE.
- Request rules:
  - Address, data and mask are stable while a request is high.
  - `bus_ren` and `bus_wen` are never high together.
  - A request is never withdrawn before `bus_ready`, except on timeout.
- `bus_ready` is ignored outside READ/WRITE. Gap states absorb the trailing ready pulse that registered single-cycle devices emit.
- `abort` is latched whenever `busy` is high. It never cuts an in-flight request.
- Timeout:
  - A counter resets on entry to READ/WRITE and counts each requesting cycle.
  - When it reaches `TIMEOUT_CYCLES` without ready: drop the request, set `error`=1, set `err_addr`=`bus_addr` → FINISH.
- Addresses wrap modulo 2^32.
- `start` while busy is ignored.
- Reset (async, any state) → IDLE. All outputs 0, `words_done`=0, counters cleared. A pending bus request is dropped immediately.

## Timing
- `start` sampled at edge 0 → `bus_ren` high in cycle 1.
- With a device that asserts ready the cycle after the request, each word costs 6 cycles: req, ready, gap, req, ready, gap.
- `done` is high in cycle 6N for N ≥ 1. The final WGAP is replaced by FINISH.
- `len_words`=0 → `done` in cycle 1, no bus activity.
- Timeout: `done` in cycle T+1 after the request's first cycle, where T = `TIMEOUT_CYCLES`.
- `busy` falls in the same cycle `done` rises.

## Structure
- Package `dma_pkg`: state enum `dma_state_t`, constant `WMASK_FULL` = 4'b1111.
- Sub-module `bus_initiator_port`: owns one request/ready/gap handshake and the timeout counter. Interface:
  - inputs: `go`, `is_write`, `addr`, `wdata`.
  - outputs: `ack`, `timeout`, `rdata_q`.
- The top-level FSM sequences read/write pairs through it.

## Test plan
- 1-cycle-ready RAM model, src 0x100, dst 0x200, len 3 → dst words equal src words, `done` in cycle 18, `words_done`=3, `error`=0.
- len 0 → `done` in cycle 1, `bus_ren`/`bus_wen` never high.
- Stale trailing ready in the gap cycle, plus a device with 3-cycle ready latency → no skipped or duplicated words, addresses strictly +4.
- dst 0x4000_0000 unmapped (ready never arrives), `TIMEOUT_CYCLES`=8 → `error`=1, `err_addr`=0x4000_0000, `words_done`=0, `done` 9 cycles after the first `bus_wen`.
- `abort` pulsed mid-READ of word 2 of 5 → word 2 completes, `done` follows, `words_done`=2.
- `rst` low during WRITE → outputs 0 asynchronously; a fresh `start` after release runs a full copy correctly.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the word-copy DMA engine and its bus port.
package dma_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_READ,
      ST_RGAP,
      ST_WRITE,
      ST_WGAP,
      ST_FINISH
   } dma_state_t;

   localparam logic [3:0] WMASK_FULL = 4'b1111;

   function automatic logic [31:0] word_align(input logic [31:0] a);
      return a & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/bus_initiator_port.sv
// One request/ready handshake on the system bus, with a per-request timeout
// and a capture register for read data.
module bus_initiator_port
   import dma_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        go,
   input  logic        is_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        ack,
   output logic        timeout,
   output logic [31:0] rdata_q,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_wmask,
   output logic        bus_wen,
   output logic        bus_ren,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ready
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt_reg;
   logic [CNT_W-1:0] wait_cnt_next;
   logic [31:0]      rdata_reg;
   logic             expired;
   logic             req;

   // Once the count hits the limit the request is dropped in that same cycle.
   assign expired = (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES));
   assign req     = go && !expired;
   assign ack     = req && bus_ready;
   assign timeout = go && expired;

   always_comb begin
      wait_cnt_next = wait_cnt_reg;
      if (!go || ack) begin
         wait_cnt_next = '0;
      end else if (!expired) begin
         wait_cnt_next = wait_cnt_reg + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wait_cnt_reg <= '0;
         rdata_reg    <= '0;
      end else begin
         wait_cnt_reg <= wait_cnt_next;
         if (ack && !is_write) begin
            rdata_reg <= bus_rdata;
         end
      end
   end

   assign rdata_q   = rdata_reg;
   assign bus_ren   = req && !is_write;
   assign bus_wen   = req && is_write;
   assign bus_addr  = req ? word_align(addr) : 32'h0;
   assign bus_wdata = bus_wen ? wdata : 32'h0;
   assign bus_wmask = bus_wen ? WMASK_FULL : 4'b0000;

endmodule

// File: rtl/bus_dma_engine.sv
// Word-copy DMA initiator: sequences read/write pairs through one bus port,
// with abort at word boundaries and timeout recovery from unmapped addresses.
module bus_dma_engine
   import dma_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int LEN_W          = 16
)
(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      src_addr,
   input  logic [31:0]      dst_addr,
   input  logic [LEN_W-1:0] len_words,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [31:0]      err_addr,
   output logic [LEN_W-1:0] words_done,
   output logic [31:0]      bus_addr,
   output logic [31:0]      bus_wdata,
   output logic [3:0]       bus_wmask,
   output logic             bus_wen,
   output logic             bus_ren,
   input  logic [31:0]      bus_rdata,
   input  logic             bus_ready
);

   dma_state_t       state_reg;
   dma_state_t       state_next;

   logic [31:0]      src_reg;
   logic [31:0]      dst_reg;
   logic [31:0]      err_addr_reg;
   logic [LEN_W-1:0] len_reg;
   logic [LEN_W-1:0] words_done_reg;
   logic             error_reg;
   logic             abort_reg;

   logic             go;
   logic             is_write;
   logic [31:0]      port_addr;
   logic             ack;
   logic             timeout;
   logic [31:0]      rdata_q;
   logic             abort_seen;
   logic             last_word;

   assign abort_seen = abort_reg || abort;
   assign last_word  = ((words_done_reg + LEN_W'(1)) == len_reg);

   bus_initiator_port #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_port (
      .clk       (clk),
      .rst       (rst),
      .go        (go),
      .is_write  (is_write),
      .addr      (port_addr),
      .wdata     (rdata_q),
      .ack       (ack),
      .timeout   (timeout),
      .rdata_q   (rdata_q),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_wmask (bus_wmask),
      .bus_wen   (bus_wen),
      .bus_ren   (bus_ren),
      .bus_rdata (bus_rdata),
      .bus_ready (bus_ready)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               state_next = (len_words == '0) ? ST_FINISH : ST_READ;
            end
         end
         ST_READ: begin
            if (timeout) begin
               state_next = ST_FINISH;
            end else if (ack) begin
               state_next = ST_RGAP;
            end
         end
         ST_RGAP: begin
            state_next = ST_WRITE;
         end
         ST_WRITE: begin
            if (timeout) begin
               state_next = ST_FINISH;
            end else if (ack) begin
               state_next = (last_word || abort_seen) ? ST_FINISH : ST_WGAP;
            end
         end
         ST_WGAP: begin
            state_next = abort_seen ? ST_FINISH : ST_READ;
         end
         ST_FINISH: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      go        = 1'b0;
      is_write  = 1'b0;
      port_addr = src_reg;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_reg)
         ST_READ: begin
            go   = 1'b1;
            busy = 1'b1;
         end
         ST_RGAP: begin
            busy = 1'b1;
         end
         ST_WRITE: begin
            go        = 1'b1;
            is_write  = 1'b1;
            port_addr = dst_reg;
            busy      = 1'b1;
         end
         ST_WGAP: begin
            busy = 1'b1;
         end
         ST_FINISH: begin
            done = 1'b1;
         end
         default: begin
            go = 1'b0;
         end
      endcase
   end

   // Datapath: pointers, counters, sticky error/abort state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         src_reg        <= '0;
         dst_reg        <= '0;
         len_reg        <= '0;
         words_done_reg <= '0;
         error_reg      <= 1'b0;
         err_addr_reg   <= '0;
         abort_reg      <= 1'b0;
      end else if (state_reg == ST_IDLE) begin
         if (start) begin
            src_reg        <= src_addr;
            dst_reg        <= dst_addr;
            len_reg        <= len_words;
            words_done_reg <= '0;
            error_reg      <= 1'b0;
            err_addr_reg   <= '0;
            abort_reg      <= 1'b0;
         end
      end else begin
         if (busy && abort) begin
            abort_reg <= 1'b1;
         end
         if (state_reg == ST_READ && ack) begin
            src_reg <= src_reg + 32'd4;
         end
         if (state_reg == ST_WRITE && ack) begin
            dst_reg        <= dst_reg + 32'd4;
            words_done_reg <= words_done_reg + LEN_W'(1);
         end
         if (timeout) begin
            error_reg    <= 1'b1;
            err_addr_reg <= word_align(port_addr);
         end
      end
   end

   assign error      = error_reg;
   assign err_addr   = err_addr_reg;
   assign words_done = words_done_reg;

endmodule

// File: tb/tb_bus_dma_engine.sv
// Scoreboard bench for bus_dma_engine with a RAM model of configurable ready
// latency, an optional trailing ready pulse, and an unmapped region.
`timescale 1ns/1ps
module tb_bus_dma_engine;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] src_addr;
   logic [31:0] dst_addr;
   logic [15:0] len_words;
   logic        abort;
   logic        busy;
   logic        done;
   logic        error;
   logic [31:0] err_addr;
   logic [15:0] words_done;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic [3:0]  bus_wmask;
   logic        bus_wen;
   logic        bus_ren;
   logic [31:0] bus_rdata;
   logic        bus_ready;

   always #5 clk = ~clk;

   bus_dma_engine #(
      .TIMEOUT_CYCLES (8),
      .LEN_W          (16)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .src_addr   (src_addr),
      .dst_addr   (dst_addr),
      .len_words  (len_words),
      .abort      (abort),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_addr   (err_addr),
      .words_done (words_done),
      .bus_addr   (bus_addr),
      .bus_wdata  (bus_wdata),
      .bus_wmask  (bus_wmask),
      .bus_wen    (bus_wen),
      .bus_ren    (bus_ren),
      .bus_rdata  (bus_rdata),
      .bus_ready  (bus_ready)
   );

   function automatic logic [31:0] pat(input logic [31:0] a);
      return 32'h5A00_0000 ^ (a * 32'h0001_0003);
   endfunction

   // RAM model: addresses below 0x1000 are mapped, everything else never answers.
   logic [31:0] mem [0:1023];
   int          lat   = 1;
   bit          stale = 1'b0;
   int          wcnt  = 0;
   int          cyc   = 0;

   assign bus_rdata = mem[bus_addr[11:2]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!rst) begin
         bus_ready <= 1'b0;
         wcnt      <= 0;
         for (int i = 0; i < 1024; i++) mem[i] <= pat(32'(i * 4));
      end else if (bus_ready) begin
         if (bus_wen) mem[bus_addr[11:2]] <= bus_wdata;
         bus_ready <= stale && (bus_ren || bus_wen);
         wcnt      <= 0;
      end else if ((bus_ren || bus_wen) && bus_addr < 32'h0000_1000) begin
         if (wcnt + 1 >= lat) bus_ready <= 1'b1;
         else wcnt <= wcnt + 1;
      end else begin
         wcnt <= 0;
      end
   end

   typedef struct {
      int          cyc;
      logic [15:0] words;
      logic        err;
      logic [31:0] eaddr;
   } done_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } xfer_t;

   done_t exp_done[$];
   xfer_t exp_rd[$];
   xfer_t exp_wr[$];
   int    total      = 0;
   int    bad        = 0;
   int    req_cycles = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   task automatic fail(input string name);
      total++;
      bad++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Monitor: pops expectations whenever the DUT completes a bus beat or a transfer.
   initial begin
      xfer_t x;
      done_t d;
      forever begin
         @(negedge clk);
         if (rst === 1'b1) begin
            if (bus_ren || bus_wen) req_cycles++;
            if (bus_ren && bus_wen) fail("ren_wen_together");
            if (bus_wen) chk("wmask", {28'h0, bus_wmask}, 32'hF);
            if (bus_ren && bus_ready) begin
               if (exp_rd.size() == 0) fail("unexpected_read");
               else begin
                  x = exp_rd.pop_front();
                  chk("rd_addr", bus_addr, x.addr);
               end
            end
            if (bus_wen && bus_ready) begin
               if (exp_wr.size() == 0) fail("unexpected_write");
               else begin
                  x = exp_wr.pop_front();
                  chk("wr_addr", bus_addr, x.addr);
                  chk("wr_data", bus_wdata, x.data);
               end
            end
            if (done) begin
               if (exp_done.size() == 0) fail("unexpected_done");
               else begin
                  d = exp_done.pop_front();
                  $display("done at cycle %0d words=%0d error=%0b err_addr=0x%08h",
                           cyc, words_done, error, err_addr);
                  chk("done_cycle", 32'(cyc), 32'(d.cyc));
                  chk("words_done", {16'h0, words_done}, {16'h0, d.words});
                  chk("error", {31'h0, error}, {31'h0, d.err});
                  chk("err_addr", err_addr, d.eaddr);
                  chk("busy_at_done", {31'h0, busy}, 32'h0);
               end
            end
         end
      end
   end

   task automatic push_copy(input logic [31:0] s, input logic [31:0] d, input int nrd, input int nwr);
      xfer_t x;
      for (int i = 0; i < nrd; i++) begin
         x.addr = s + 32'(4 * i);
         x.data = 32'h0;
         exp_rd.push_back(x);
      end
      for (int i = 0; i < nwr; i++) begin
         x.addr = d + 32'(4 * i);
         x.data = pat(s + 32'(4 * i));
         exp_wr.push_back(x);
      end
   endtask

   // Drives start for one cycle; returns at the negedge of cycle 1.
   task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                         input int delta, input logic [15:0] ewords, input logic eerr,
                         input logic [31:0] eaddr);
      done_t e;
      @(negedge clk);
      src_addr  = s;
      dst_addr  = d;
      len_words = n;
      start     = 1'b1;
      if (delta > 0) begin
         e.cyc   = cyc + delta;
         e.words = ewords;
         e.err   = eerr;
         e.eaddr = eaddr;
         exp_done.push_back(e);
      end
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      bit seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         if (done === 1'b1) seen = 1'b1;
         else @(negedge clk);
      end
      if (!seen) fail({name, "_done_timeout"});
      repeat (2) @(negedge clk);
   endtask

   initial begin
      int snap;
      rst       = 1'b0;
      start     = 1'b0;
      abort     = 1'b0;
      src_addr  = 32'h0;
      dst_addr  = 32'h0;
      len_words = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'h0, busy}, 32'h0);
      chk("rst_done", {31'h0, done}, 32'h0);
      chk("rst_ren_wen", {30'h0, bus_ren, bus_wen}, 32'h0);
      chk("rst_words_done", {16'h0, words_done}, 32'h0);
      chk("rst_bus_addr", bus_addr, 32'h0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Basic 3-word copy with 1-cycle ready: done in cycle 18.
      lat = 1; stale = 1'b0;
      push_copy(32'h100, 32'h200, 3, 3);
      launch(32'h100, 32'h200, 16'd3, 18, 16'd3, 1'b0, 32'h0);
      wait_done("copy3", 100);

      // Zero length: done in cycle 1 with no bus activity.
      snap = req_cycles;
      launch(32'h100, 32'h200, 16'd0, 1, 16'd0, 1'b0, 32'h0);
      wait_done("len0", 10);
      chk("len0_no_bus", 32'(req_cycles - snap), 32'h0);

      // 3-cycle ready latency plus trailing ready pulse: 10 cycles per word.
      lat = 3; stale = 1'b1;
      push_copy(32'h300, 32'h380, 4, 4);
      launch(32'h300, 32'h380, 16'd4, 40, 16'd4, 1'b0, 32'h0);
      wait_done("lat3_stale", 200);

      // Unmapped destination: first bus_wen in cycle 4, done 9 cycles later.
      lat = 1; stale = 1'b0;
      push_copy(32'h800, 32'h0, 1, 0);
      launch(32'h800, 32'h4000_0000, 16'd1, 13, 16'd0, 1'b1, 32'h4000_0000);
      wait_done("timeout", 100);
      repeat (3) @(negedge clk);
      chk("error_hold", {31'h0, error}, 32'h1);
      chk("err_addr_hold", err_addr, 32'h4000_0000);

      // Abort during word 2 read of 5: word 2 completes, done in cycle 12.
      push_copy(32'h400, 32'h500, 2, 2);
      launch(32'h400, 32'h500, 16'd5, 12, 16'd2, 1'b0, 32'h0);
      repeat (6) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      wait_done("abort", 100);

      // Reset while writing word 2: everything drops at once.
      push_copy(32'h600, 32'h700, 2, 1);
      launch(32'h600, 32'h700, 16'd2, -1, 16'd0, 1'b0, 32'h0);
      repeat (9) @(negedge clk);
      chk("pre_reset_wen", {31'h0, bus_wen}, 32'h1);
      chk("pre_reset_words", {16'h0, words_done}, 32'h1);
      #2;
      rst = 1'b0;
      #1;
      chk("async_rst_wen", {31'h0, bus_wen}, 32'h0);
      chk("async_rst_busy", {31'h0, busy}, 32'h0);
      chk("async_rst_addr", bus_addr, 32'h0);
      chk("async_rst_wdata", bus_wdata, 32'h0);
      chk("async_rst_words", {16'h0, words_done}, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // Fresh copy after reset release.
      push_copy(32'h610, 32'h710, 3, 3);
      launch(32'h610, 32'h710, 16'd3, 18, 16'd3, 1'b0, 32'h0);
      wait_done("post_reset", 100);

      chk("rd_left", 32'(exp_rd.size()), 32'h0);
      chk("wr_left", 32'(exp_wr.size()), 32'h0);
      chk("done_left", 32'(exp_done.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired (cycle %0d)", cyc);
      $fatal(1);
   end

endmodule
